// File: rtl/line_div_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_div_seq_if: operand, divider-controller and result streams of line_div_seq
// Rev 1.0
// ----------------------------------------------------------------------------
interface line_div_seq_if #(
  parameter int DW = 16,
  parameter int QW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_num;
  logic [QW-1:0] in_den;
  logic          div_start;
  logic [DW-1:0] div_num;
  logic [QW-1:0] div_den;
  logic          div_done;
  logic [QW-1:0] div_quot;
  logic          out_valid;
  logic          out_ready;
  logic [QW-1:0] out_quot;
  logic          out_sat;
  logic          out_eol;
  logic          err_timeout;

  modport master (
    input  in_valid, in_num, in_den, div_done, div_quot, out_ready,
    output in_ready, div_start, div_num, div_den, out_valid, out_quot,
           out_sat, out_eol, err_timeout
  );

  modport slave (
    output in_valid, in_num, in_den, div_done, div_quot, out_ready,
    input  in_ready, div_start, div_num, div_den, out_valid, out_quot,
           out_sat, out_eol, err_timeout
  );
endinterface
`default_nettype wire

// File: rtl/line_div_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// line_div_seq: operand sequencer and saturating result FIFO for the line divider
// Rev 1.0
// ----------------------------------------------------------------------------
module line_div_seq #(
  parameter int DW       = 16,
  parameter int QW       = 8,
  parameter int DEPTH    = 4,
  parameter int LINE_LEN = 640,
  parameter int TIMEOUT  = 32
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  line_div_seq_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam int LW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [LW-1:0] C_LINE_LAST = LW'(LINE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ZERO  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] num_q;
  logic [QW-1:0] den_q;
  logic [QW:0]   fifo_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic [LW-1:0] line_q;
  logic          err_q;

  logic          accept, pop, push, push_sat, set_tmo, start;
  logic [QW-1:0] push_quot;

  // Only one operation is ever in flight, so a slot free at accept time is still free at write time.
  assign accept = (state_q == IDLE) && (cnt_q < C_DEPTH) && bus.in_valid;
  assign pop    = (cnt_q != '0) && bus.out_ready;

  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    push      = 1'b0;
    push_quot = '1;
    push_sat  = 1'b1;
    set_tmo   = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (bus.in_den == '0) ? ZERO : ISSUE;
      end
      ISSUE: begin
        start   = 1'b1;
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (bus.div_done) begin
          push      = 1'b1;
          push_quot = bus.div_quot;
          push_sat  = 1'b0;
          state_d   = IDLE;
        end else if (tcnt_q == C_TMO_LAST) begin
          push    = 1'b1;
          set_tmo = 1'b1;
          state_d = IDLE;
        end
      end
      ZERO: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      num_q   <= '0;
      den_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (accept) begin
        num_q <= bus.in_num;
        den_q <= bus.in_den;
      end
      if (push) begin
        fifo_q[wr_q] <= {push_sat, push_quot};
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q   <= rd_q + 1'b1;
        line_q <= (line_q == C_LINE_LAST) ? '0 : line_q + 1'b1;
      end
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (set_tmo) err_q <= 1'b1;
    end
  end

  assign bus.in_ready    = (state_q == IDLE) && (cnt_q < C_DEPTH);
  assign bus.div_start   = start;
  assign bus.div_num     = num_q;
  assign bus.div_den     = den_q;
  assign bus.out_valid   = (cnt_q != '0);
  assign bus.out_sat     = fifo_q[rd_q][QW];
  assign bus.out_quot    = fifo_q[rd_q][QW-1:0];
  assign bus.out_eol     = (cnt_q != '0) && (line_q == C_LINE_LAST);
  assign bus.err_timeout = err_q;
endmodule
`default_nettype wire

// File: tb/tb_line_div_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_line_div_seq: directed and random checks of line_div_seq against a result-queue model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_line_div_seq;
  localparam int DW       = 16;
  localparam int QW       = 8;
  localparam int DEPTH    = 4;
  localparam int LINE_LEN = 3;
  localparam int TIMEOUT  = 32;
  localparam int LAT      = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  line_div_seq_if #(.DW(DW), .QW(QW)) bus ();

  line_div_seq #(
    .DW(DW), .QW(QW), .DEPTH(DEPTH), .LINE_LEN(LINE_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int          checks = 0;
  int          failures = 0;
  int          start_cnt = 0;
  int          stable_err = 0;
  int          pops = 0;
  int          accepted = 0;
  bit          tmo_mode = 1'b0;
  logic [15:0] eol_obs = '0;
  logic [QW:0] exp_q [$];

  // Divider controller model: answers LAT cycles after sampling div_start, unless in timeout mode.
  bit            m_busy = 1'b0;
  bit            m_abort = 1'b0;
  int            m_cd = 0;
  logic [DW-1:0] m_num;
  logic [QW-1:0] m_den;
  initial begin
    bus.div_done = 1'b0;
    bus.div_quot = '0;
    forever begin
      @(posedge clk);
      #2;
      bus.div_done = 1'b0;
      if (m_busy) begin
        if (!rst_n) m_abort = 1'b1;
        m_cd--;
        if (m_cd == 0) begin
          m_busy       = 1'b0;
          bus.div_done = 1'b1;
          bus.div_quot = (bus.div_den == '0) ? '0 : QW'(int'(bus.div_num) / int'(bus.div_den));
          if (!m_abort && (bus.div_num !== m_num || bus.div_den !== m_den)) stable_err++;
        end
      end
      if (bus.div_start === 1'b1) begin
        start_cnt++;
        if (!tmo_mode) begin
          m_busy  = 1'b1;
          m_cd    = LAT;
          m_num   = bus.div_num;
          m_den   = bus.div_den;
          m_abort = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [QW:0] ref_res(input logic [DW-1:0] n, input logic [QW-1:0] d,
                                          input bit tmo);
    int unsigned q;
    if (d == '0 || tmo) return {1'b1, {QW{1'b1}}};
    q = int'(n) / int'(d);
    return {1'b0, q[QW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock: score the handshakes that fire at the coming edge, then advance.
  task automatic step();
    bit          in_fire, out_fire;
    logic [QW:0] e;
    logic        eol_e;
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        chk("pop_unexpected", 32'(exp_q.size()), 1);
      end else begin
        e     = exp_q.pop_front();
        eol_e = (pops % LINE_LEN) == (LINE_LEN - 1);
        chk("pop_result", {bus.out_eol, bus.out_sat, bus.out_quot}, {eol_e, e});
        if (pops < 16) eol_obs[pops] = bus.out_eol;
        pops++;
      end
    end
    if (in_fire) begin
      exp_q.push_back(ref_res(bus.in_num, bus.in_den, tmo_mode));
      accepted++;
    end
    tick();
    if (in_fire) bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] num, input logic [QW-1:0] den);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_num   = num;
    bus.in_den   = den;
    for (int k = 0; k < 400 && !ok; k++) begin
      ok = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 32'(ok), 1);
  endtask

  task automatic wait_valid(input int maxn, output int n);
    n = 0;
    while (!bus.out_valid && n < maxn) begin
      step();
      n++;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && (exp_q.size() != 0 || bus.in_valid); k++) step();
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();
    exp_q.delete();
    pops    = 0;
    eol_obs = '0;
    rst_n   = 1'b1;
  endtask

  initial begin
    int n;
    int s0;
    int a0;
    int p0;
    bus.in_valid  = 1'b0;
    bus.in_num    = '0;
    bus.in_den    = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_div_ops", {bus.div_num, bus.div_den}, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_head", {bus.out_eol, bus.out_sat, bus.out_quot}, 0);
    chk("rst_err", bus.err_timeout, 0);
    rst_n = 1'b1;
    tick();

    // Single divide
    s0 = start_cnt;
    send(16'd1000, 8'd7);
    chk("single_start", bus.div_start, 1);
    chk("single_ops", {bus.div_num, bus.div_den}, {16'd1000, 8'd7});
    chk("single_ready_busy", bus.in_ready, 0);
    wait_valid(60, n);
    chk("single_latency", n, LAT + 1);
    chk("single_head", {bus.out_valid, bus.out_sat, bus.out_quot}, {1'b1, 1'b0, 8'd142});
    chk("single_ready_back", bus.in_ready, 1);
    chk("single_starts", start_cnt - s0, 1);
    chk("single_stable", stable_err, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single_popped", bus.out_valid, 0);

    // Zero denominator
    s0 = start_cnt;
    send(16'd500, 8'd0);
    chk("zero_not_yet", bus.out_valid, 0);
    step();
    chk("zero_head", {bus.out_valid, bus.out_sat, bus.out_quot}, {1'b1, 1'b1, 8'hFF});
    step();
    step();
    chk("zero_no_start", start_cnt - s0, 0);
    chk("zero_err", bus.err_timeout, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Timeout: the divider never answers
    tmo_mode = 1'b1;
    s0 = start_cnt;
    send(16'd1234, 8'd5);
    chk("tmo_err_before", bus.err_timeout, 0);
    wait_valid(80, n);
    chk("tmo_latency", n, TIMEOUT + 1);
    chk("tmo_head", {bus.out_valid, bus.out_sat, bus.out_quot}, {1'b1, 1'b1, 8'hFF});
    chk("tmo_err_set", bus.err_timeout, 1);
    chk("tmo_starts", start_cnt - s0, 1);
    tmo_mode = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    send(16'd90, 8'd9);
    repeat (LAT + 4) step();
    chk("tmo_err_sticky", bus.err_timeout, 1);
    bus.out_ready = 1'b1;
    drain();
    bus.out_ready = 1'b0;

    // Reset while waiting on the divider, then a late div_done in IDLE
    send(16'd9, 8'd0);
    step();
    send(16'd3000, 8'd10);
    repeat (3) step();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_start", bus.div_start, 0);
    chk("mid_rst_err", bus.err_timeout, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    exp_q.delete();
    pops    = 0;
    eol_obs = '0;
    repeat (LAT + 6) step();
    chk("spurious_done", bus.out_valid, 0);

    // Line marker with LINE_LEN = 3
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(16'(100 + i * 37), (i % 2 == 0) ? 8'd0 : 8'(i + 2));
    drain();
    chk("line_pops", pops, 7);
    chk("line_eol_pattern", eol_obs[6:0], 7'b0100100);
    send(16'd77, 8'd0);
    send(16'd78, 8'd3);
    drain();
    chk("line_after_wrap", eol_obs[8:7], 2'b10);

    // Backpressure: five operands against a four-entry FIFO
    bus.out_ready = 1'b0;
    a0 = accepted;
    p0 = pops;
    for (int i = 0; i < 4; i++) send(16'($urandom), 8'($urandom_range(1, 255)));
    repeat (LAT + 4) step();
    chk("bp_full_ready", bus.in_ready, 0);
    chk("bp_full_valid", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.in_num   = 16'($urandom);
    bus.in_den   = 8'($urandom_range(1, 255));
    repeat (6) step();
    chk("bp_fifth_held", accepted - a0, 4);
    bus.out_ready = 1'b1;
    drain();
    chk("bp_all_accepted", accepted - a0, 5);
    chk("bp_all_popped", pops - p0, 5);

    // Random traffic with random downstream stalls
    for (int i = 0; i < 600; i++) begin
      if (!bus.in_valid && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b1;
        bus.in_num   = 16'($urandom);
        bus.in_den   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.out_ready = 1'b1;
    drain();
    chk("rand_stable", stable_err, 0);
    chk("rand_err_clear", bus.err_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/line_div_seq.md
# line_div_seq

Operand sequencer and result buffer for the line divider in we_core. Accepts numerator/denominator pairs over a valid/ready stream, issues a one-cycle `div_start` to the divider controller, and holds operands stable until the controller's done pulse. It captures the quotient into a small FIFO and streams results downstream with an end-of-line marker. Zero denominators and divider timeouts are handled locally, so the pipeline never stalls.

## Interface
- `DW`, 16, numerator width
- `QW`, 8, denominator/quotient width
- `DEPTH`, 4, result FIFO depth (power of 2, ≥2)
- `LINE_LEN`, 640, results per line (≥1)
- `TIMEOUT`, 32, max cycles from `div_start` to `div_done` (≥12)
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block accepts operand pair
- `in_num`  in  DW  numerator
- `in_den`  in  QW  denominator
- `div_start`  out  1  one-cycle start pulse to the divider controller
- `div_num`  out  DW  registered numerator, held stable from `div_start` until done
- `div_den`  out  QW  registered denominator, held likewise
- `div_done`  in  1  one-cycle completion pulse from the divider controller
- `div_quot`  in  QW  quotient, valid in the `div_done` cycle
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  downstream accepts
- `out_quot`  out  QW  quotient at FIFO head
- `out_sat`  out  1  head result saturated (zero denominator or timeout)
- `out_eol`  out  1  head result is the last of the current line
- `err_timeout`  out  1  sticky; set by any timeout

## Operation
- FSM states:
  - IDLE
    - `in_ready` = 1 iff FIFO count < DEPTH.
    - On `in_valid & in_ready`: register `div_num`/`div_den`.
    - If `in_den == 0`, go to ZERO; otherwise go to ISSUE.
  - ISSUE
    - Assert `div_start` for exactly this cycle and clear the timeout counter.
    - Go to WAIT.
  - WAIT
    - Timeout counter increments each cycle.
    - On `div_done`: write {`div_quot`, sat=0} to the FIFO, then go to IDLE.
    - When the counter reaches TIMEOUT−1 without `div_done`: write {all-ones, sat=1}, set `err_timeout`, then go to IDLE.
  - ZERO
    - Write {all-ones, sat=1} to the FIFO, then go to IDLE. No `div_start` is issued.
- Slot reservation: `in_ready` is checked before accepting, and only one operation is ever in flight, so a FIFO write never finds the FIFO full. The FIFO write happens in the same cycle as a possible pop, and simultaneous push/pop keeps the count unchanged.
- `div_done` outside WAIT is ignored: no write, no flag.
- `in_ready` = 0 in ISSUE, WAIT and ZERO.
- FIFO:
  - DEPTH entries of {quot, sat}.
  - Read/write pointers wrap modulo DEPTH.
  - Count range is 0..DEPTH.
  - Outputs are driven from the head entry.
- Line counter:
  - Width clog2(LINE_LEN).
  - Increments on each pop (`out_valid & out_ready`) and wraps to 0 after LINE_LEN−1.
  - `out_eol` = `out_valid` && counter == LINE_LEN−1.
  - With LINE_LEN = 1, every result is EOL.
- `err_timeout` is cleared only by reset.

## Timing
- Reset values:
  - FSM = IDLE, FIFO empty, line counter = 0.
  - `in_ready` = 1 (FIFO empty).
  - `div_start` = 0, `div_num` = 0, `div_den` = 0.
  - `out_valid` = 0, `out_quot` = 0, `out_sat` = 0, `out_eol` = 0.
  - `err_timeout` = 0.
- Reset mid-operation: everything returns to the reset values on the next edge, and in-flight results are discarded.
- Accept at edge T:
  - `div_start` is high during cycle T+1.
  - The divider controller returns `div_done` nominally 10 cycles after its start sample.
  - A FIFO write on `div_done` at edge D makes `out_valid` high in cycle D+1 (if the FIFO was empty), and `in_ready` returns in cycle D+1.
- Zero denominator: accept at T → entry visible in cycle T+2.
- Timeout: the saturated entry is written at edge T+1+TIMEOUT.
- Throughput: one operand per divider latency + 2 cycles. Output FIFO pop is one per cycle.

## Test plan
- **Single divide:** `in_num`=1000, `in_den`=7; model returns `div_quot`=142 10 cycles after `div_start`.
  - Exactly one `div_start` pulse.
  - `div_num`/`div_den` stable until done.
  - `out_quot`=142, `out_sat`=0 one cycle after `div_done`.
- **Zero denominator:** `in_den`=0 → no `div_start`; `out_quot`=0xFF, `out_sat`=1 two cycles after accept; `err_timeout` stays 0.
- **Timeout:** model never asserts `div_done` → entry 0xFF, sat=1, written at edge T+1+32; `err_timeout`=1 and held until `rst_n` is low.
- **Backpressure:** `out_ready`=0 and 5 operands offered with DEPTH=4.
  - `in_ready` drops after the 4th result is stored.
  - Releasing `out_ready` pops in order and the 5th is accepted.
  - No loss or duplication.
- **Line marker:** LINE_LEN=3, 7 results popped → `out_eol` on pops 3 and 6 only; counter = 1 at end.
- **Reset/spurious:** assert `rst_n`=0 in WAIT.
  - FIFO empty, `div_start`=0 after the edge.
  - A late `div_done` in IDLE creates no entry.
